// File: rtl/mpi_noc_tx_bridge.sv
// Credit-gated egress bridge: buffers local NoC flits and forwards them toward the MPI send path
// only while the remote rank has free slots; returns yummies locally and drains on finalize.
module mpi_noc_tx_bridge #(
    parameter int DATA_W      = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int MPI_CREDITS = 4,
    localparam int CW = $clog2(MPI_CREDITS + 1),
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              noc_valid_i,
    input  logic [DATA_W-1:0] noc_data_i,
    output logic              noc_yummy_o,
    output logic              mpi_valid_o,
    output logic [DATA_W-1:0] mpi_data_o,
    input  logic              mpi_yummy_i,
    input  logic              finalize_i,
    output logic [CW-1:0]     credits_o,
    output logic              done_o,
    output logic              error_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0] CRED_MAX = CW'(MPI_CREDITS);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic [1:0]        state_q, state_d;
    logic              mpi_valid_q, mpi_valid_d;
    logic              noc_yummy_q, noc_yummy_d;
    logic [DATA_W-1:0] mpi_data_q, mpi_data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic fifo_empty;
    logic fifo_full;
    logic accepting;
    logic pop;
    logic push;
    logic sat_err;

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        accepting  = (state_q != ST_DONE);
        pop        = !fifo_empty && (credits_q != '0) && accepting;
        // A pop frees the head slot this edge, so a full FIFO can still take a flit.
        push       = noc_valid_i && accepting && (!fifo_full || pop);

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        credits_d = credits_q;
        sat_err   = 1'b0;
        if (mpi_yummy_i && !pop) begin
            if (credits_q == CRED_MAX) begin
                sat_err = 1'b1;
            end else begin
                credits_d = credits_q + CRED_ONE;
            end
        end else if (!mpi_yummy_i && pop) begin
            credits_d = credits_q - CRED_ONE;
        end

        error_d = error_q | (noc_valid_i && !push) | sat_err;

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (finalize_i) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && !pop && (credits_q == CRED_MAX)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase

        mpi_valid_d = pop;
        noc_yummy_d = pop;
        mpi_data_d  = pop ? mem_q[rd_ptr_q[AW-1:0]] : mpi_data_q;
        done_d      = (state_d == ST_DONE);
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= noc_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            credits_q   <= CRED_MAX;
            state_q     <= ST_RUN;
            mpi_valid_q <= 1'b0;
            noc_yummy_q <= 1'b0;
            mpi_data_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            credits_q   <= credits_d;
            state_q     <= state_d;
            mpi_valid_q <= mpi_valid_d;
            noc_yummy_q <= noc_yummy_d;
            mpi_data_q  <= mpi_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mpi_valid_o = mpi_valid_q;
    assign noc_yummy_o = noc_yummy_q;
    assign mpi_data_o  = mpi_data_q;
    assign credits_o   = credits_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: doc/mpi_noc_tx_bridge.md
# mpi_noc_tx_bridge

Credit-based egress stage between a local NoC node and the MPI send path of the co-simulation harness. Each cycle it accepts at most one flit (valid/data) from the local node, buffers it, and forwards it as a registered valid/data pair that the harness passes to the MPI send call toward the remote rank. It does not forward a flit unless the remote rank holds a free buffer slot, tracked by a counter of remote credits that the returned yummy pulses refill. It also returns yummies to the local node and runs a finalize drain sequence, so the harness ends only after all in-flight flits are acknowledged.

## Interface
- DATA_W, 64, flit width
- FIFO_DEPTH, 4, local buffer depth; power of two, ≥2; equals the credits the local node starts with
- MPI_CREDITS, 4, remote buffer depth; initial credit count, ≥1
- clk_i  in  1  clock; all state on rising edge
- rstn_i  in  1  asynchronous active-low reset
- noc_valid_i  in  1  flit valid from local node
- noc_data_i  in  DATA_W  flit payload
- noc_yummy_o  out  1  one-cycle credit return to local node
- mpi_valid_o  out  1  flit valid toward MPI send
- mpi_data_o  out  DATA_W  flit payload toward MPI send
- mpi_yummy_i  in  1  credit returned by remote rank, one per flit consumed
- finalize_i  in  1  drain request; level, sampled each edge
- credits_o  out  $clog2(MPI_CREDITS+1)  current remote credit count
- done_o  out  1  drain complete, harness may finalize
- error_o  out  1  sticky protocol error

## Operation
- FIFO of FIFO_DEPTH entries, pointers with one extra wrap bit; full = same index and wrap bits differ, empty = pointers equal.
- Push: noc_valid_i=1 and state is RUN or DRAIN and FIFO not full. noc_valid_i while full: flit dropped, error_o set. noc_valid_i in DONE: flit dropped, error_o set.
- Pop at an edge when FIFO not empty, credit register > 0 and state is not DONE. A pop loads mpi_data_o with the head entry, sets mpi_valid_o=1 and noc_yummy_o=1 for the next cycle. With no pop, both are 0 and mpi_data_o keeps its value.
- Credit update per edge: −1 on pop, +1 on mpi_yummy_i; both together leave the count unchanged. mpi_yummy_i at count = MPI_CREDITS with no pop: count saturates and error_o is set.
- Push and pop in the same edge are allowed at any occupancy (full included). Occupancy stays unchanged.
- FSM:
  - RUN → DRAIN when finalize_i=1.
  - DRAIN → DONE when FIFO empty, no pop this edge and credits = MPI_CREDITS.
  - DONE holds until reset.
  - finalize_i deasserting in DRAIN does not return the FSM to RUN.
- done_o = (state == DONE), registered.

## Timing
- Reset values: mpi_valid_o=0, mpi_data_o=0, noc_yummy_o=0, credits_o=MPI_CREDITS, done_o=0, error_o=0, FIFO empty, state RUN.
- Reset mid-operation discards buffered flits and outstanding credits immediately; there is no drain.
- Latency: flit pushed at edge k pops at edge k+1 at the earliest, so mpi_valid_o is high during cycle k+1..k+2.
- Pop decision uses the registered credit count. mpi_yummy_i arriving at edge k when the count is 0 enables a pop at edge k+1, not at edge k.
- Throughput: one flit per cycle while credits > 0 and FIFO not empty.
- noc_yummy_o is coincident with mpi_valid_o, one pulse per forwarded flit.
- error_o stays high until reset.

## Test plan
- Reset then single flit 0x1234 at edge 1 → mpi_valid_o=1 with data 0x1234 in cycle 2 only, noc_yummy_o=1 same cycle, credits_o 4→3.
- Eight back-to-back flits, no mpi_yummy_i → exactly 4 forwarded on consecutive cycles, credits_o=0, remaining 4 held in order. Then one yummy per cycle → remaining flits forwarded in order, one cycle after each yummy.
- Credits=0, FIFO full, noc_valid_i asserted with simultaneous pop enabled by a yummy → no error, occupancy stays 4. Extra push while full without pop → flit dropped, error_o=1.
- mpi_yummy_i with credits_o=4 → credits_o stays 4, error_o=1. Pop and yummy on the same edge → count unchanged.
- finalize_i with 2 flits buffered and 3 credits outstanding → both flits forwarded. done_o rises only after all 4 credits return: 1 cycle after the final yummy edge. A later noc_valid_i → dropped, error_o=1.
- Async reset asserted mid-stream between edges → all outputs reach reset values immediately, credits_o=4, no mpi_valid_o until a new flit is pushed.
